pipe_reg_skid: RTL and testbench

PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

---
 rtl/qtpa_pkg.sv | 24 ++
 rtl/pipe_reg_skid.sv | 133 +++++++++++++
 tb/tb_pipe_reg_skid.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/qtpa_pkg.sv
// Shared types for the execute->writeback pipeline register: payload layout and
// the occupancy-state encoding used by pipe_reg_skid.
package qtpa_pkg;

    localparam int unsigned DATA_WIDTH = 16;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] alu_result;
        logic [3:0]            rd_addr;
        logic                  we;
        logic                  flag_zero;
        logic                  flag_carry;
        logic                  flag_ovf;
    } ex_wb_payload_t;

    localparam int unsigned QTPA_PAYLOAD_W = $bits(ex_wb_payload_t);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_reg_skid.sv
// Valid/ready pipeline stage: either a two-entry skid buffer with a flopped
// in_ready, or a single register with combinational in_ready.
module pipe_reg_skid
    import qtpa_pkg::*;
#(
    parameter int unsigned PAYLOAD_W  = QTPA_PAYLOAD_W,
    parameter bit          SKID_EN    = 1'b1,
    parameter bit          FLUSH_ZERO = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_data,
    input  logic                 out_ready,
    output logic [1:0]           occupancy
);

    logic                 r_out_valid;
    logic [PAYLOAD_W-1:0] r_out_data;

    logic                 w_skid_valid;
    logic [PAYLOAD_W-1:0] w_skid_data;
    logic                 w_skid_load;
    logic                 w_skid_clr;
    logic                 w_skid_zero;

    logic                 w_in_xfer;
    logic                 w_out_xfer;
    logic                 w_nxt_out_valid;
    logic [PAYLOAD_W-1:0] w_nxt_out_data;
    skid_state_e          w_state;

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = r_out_valid & out_ready;
    assign w_state    = w_skid_valid ? ST_FULL : (r_out_valid ? ST_ONE : ST_EMPTY);

    always_comb begin
        w_nxt_out_valid = r_out_valid;
        w_nxt_out_data  = r_out_data;
        w_skid_load     = 1'b0;
        w_skid_clr      = 1'b0;
        w_skid_zero     = 1'b0;
        case (w_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_nxt_out_valid = 1'b1;
                    w_nxt_out_data  = in_data;
                end
            end
            ST_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_nxt_out_data = in_data;
                end else if (w_in_xfer) begin
                    w_skid_load = 1'b1;
                end else if (w_out_xfer) begin
                    w_nxt_out_valid = 1'b0;
                end
            end
            ST_FULL: begin
                if (w_out_xfer) begin
                    w_nxt_out_data = w_skid_data;
                    w_skid_clr     = 1'b1;
                end
            end
            default: begin
                w_nxt_out_valid = 1'b0;
                w_skid_clr      = 1'b1;
            end
        endcase
        // Flush overrides everything: the offered payload is dropped and any
        // coinciding out-transfer still completes from the current out_data.
        if (flush) begin
            w_nxt_out_valid = 1'b0;
            w_skid_load     = 1'b0;
            w_skid_clr      = 1'b1;
            if (FLUSH_ZERO) begin
                w_nxt_out_data = '0;
                w_skid_zero    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= w_nxt_out_valid;
            r_out_data  <= w_nxt_out_data;
        end
    end

    generate
        if (SKID_EN) begin : g_skid
            logic                 r_skid_valid;
            logic [PAYLOAD_W-1:0] r_skid_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_skid_valid <= 1'b0;
                    r_skid_data  <= '0;
                end else begin
                    if (w_skid_load) begin
                        r_skid_valid <= 1'b1;
                        r_skid_data  <= in_data;
                    end else if (w_skid_clr) begin
                        r_skid_valid <= 1'b0;
                    end
                    if (w_skid_zero) r_skid_data <= '0;
                end
            end

            assign w_skid_valid = r_skid_valid;
            assign w_skid_data  = r_skid_data;
            assign in_ready     = ~r_skid_valid;
        end else begin : g_noskid
            logic w_unused;
            assign w_unused     = ^{w_skid_load, w_skid_clr, w_skid_zero};
            assign w_skid_valid = 1'b0;
            assign w_skid_data  = '0;
            assign in_ready     = out_ready | ~r_out_valid;
        end
    endgenerate

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign occupancy = {1'b0, r_out_valid} + {1'b0, w_skid_valid};

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid: three configurations (skid/zero-flush, no-skid,
// skid/hold-flush) share stimulus; a per-instance queue scoreboard checks order.
module tb_pipe_reg_skid;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;

    logic         ir [3];
    logic         ov [3];
    logic [W-1:0] od [3];
    logic [1:0]   oc [3];

    logic [W-1:0] q [3][$];
    logic         stl [3];
    logic [W-1:0] sd [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_reg_skid #(.PAYLOAD_W(W), .SKID_EN(1'b1), .FLUSH_ZERO(1'b1)) u_d1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready),
        .occupancy(oc[0]));

    pipe_reg_skid #(.PAYLOAD_W(W), .SKID_EN(1'b0), .FLUSH_ZERO(1'b1)) u_d0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready),
        .occupancy(oc[1]));

    pipe_reg_skid #(.PAYLOAD_W(W), .SKID_EN(1'b1), .FLUSH_ZERO(1'b0)) u_dz (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir[2]), .out_valid(ov[2]), .out_data(od[2]), .out_ready(out_ready),
        .occupancy(oc[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: at the falling edge the inputs for the next rising edge are
    // stable, so transfers are predicted here and the queue updated at once.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("d%0d_occ", k), oc[k], q[k].size());
            chk($sformatf("d%0d_ovld", k), ov[k], q[k].size() != 0);
            if (k == 1) chk($sformatf("d%0d_irdy", k), ir[k], out_ready || q[k].size() == 0);
            else        chk($sformatf("d%0d_irdy", k), ir[k], q[k].size() < 2);
            if (stl[k] && ov[k]) chk($sformatf("d%0d_stable", k), od[k], sd[k]);
            stl[k] = ov[k] && !out_ready && !rst && !flush;
            sd[k]  = od[k];
            if (rst) begin
                q[k].delete();
            end else begin
                if (ov[k] && out_ready) begin
                    chk($sformatf("d%0d_pop_avail", k), q[k].size() != 0, 1'b1);
                    if (q[k].size() != 0) chk($sformatf("d%0d_order", k), od[k], q[k].pop_front());
                end
                if (flush) q[k].delete();
                else if (in_valid && ir[k]) q[k].push_back(in_data);
            end
        end
    end

    initial begin
        logic [W-1:0] strm [3];
        for (int k = 0; k < 3; k++) begin
            stl[k] = 1'b0;
            sd[k]  = '0;
        end
        strm[0] = 16'h11; strm[1] = 16'h22; strm[2] = 16'h33;

        // reset
        step(); step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_occ%0d", k), oc[k], 2'd0);
            chk($sformatf("rst_ov%0d", k), ov[k], 1'b0);
            chk($sformatf("rst_od%0d", k), od[k], 16'h0);
            chk($sformatf("rst_ir%0d", k), ir[k], 1'b1);
        end

        // streaming with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = strm[i];
            step();
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("strm_od%0d", k), od[k], strm[i]);
                chk($sformatf("strm_occ%0d", k), oc[k], 2'd1);
            end
        end
        in_valid = 1'b0;
        step();
        chk("strm_drain_ov", ov[0], 1'b0);

        // fill the skid under backpressure, then release
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'hA0;
        step();
        chk("fill1_occ", oc[0], 2'd1);
        chk("fill1_ir", ir[0], 1'b1);
        chk("nos_ir_stall", ir[1], 1'b0);
        in_data = 16'hB0;
        step();
        chk("fill2_occ", oc[0], 2'd2);
        chk("fill2_ir", ir[0], 1'b0);
        chk("fill2_od", od[0], 16'hA0);
        chk("nos_hold_od", od[1], 16'hA0);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("rel1_od", od[0], 16'hB0);
        chk("rel1_occ", oc[0], 2'd1);
        step();
        chk("rel2_occ", oc[0], 2'd0);

        // flush while full with a payload offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'hA1;
        step();
        in_data = 16'hB1;
        step();
        chk("pre_flush_occ", oc[0], 2'd2);
        flush = 1'b1; in_data = 16'hC0;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_occ", oc[0], 2'd0);
        chk("flush_ov", ov[0], 1'b0);
        chk("flush_od_zero", od[0], 16'h0);
        chk("flush_occ_hold", oc[2], 2'd0);
        chk("flush_od_hold", od[2], 16'hA1);
        out_ready = 1'b1;
        step();
        chk("flush_no_c0", ov[0], 1'b0);
        chk("flush_no_c0_nos", ov[1], 1'b0);

        // reset while full, mid-transfer
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'hA2;
        step();
        in_data = 16'hB2;
        step();
        chk("pre_rst_occ", oc[2], 2'd2);
        rst = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("mrst_occ%0d", k), oc[k], 2'd0);
            chk($sformatf("mrst_ov%0d", k), ov[k], 1'b0);
            chk($sformatf("mrst_od%0d", k), od[k], 16'h0);
            chk($sformatf("mrst_ir%0d", k), ir[k], 1'b1);
        end

        // single-register stage: full throughput with combinational in_ready
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 16'hD0 + W'(i);
            #1;
            if (i > 0) chk("nos_ir_thru", ir[1], 1'b1);
            step();
            chk("nos_od_thru", od[1], 16'hD0 + W'(i));
            chk("nos_ov_thru", ov[1], 1'b1);
        end
        in_valid = 1'b0;
        step();

        // random stress
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            in_data   = W'($urandom);
            flush     = ($urandom_range(0, 299) == 0);
            rst       = ($urandom_range(0, 1999) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        for (int k = 0; k < 3; k++) chk($sformatf("drain%0d", k), q[k].size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
